// File: rtl/ltsm_sbinit_ctrl.sv
// ltsm_sbinit_ctrl: SBINIT sub-state controller of the LTSM.
// Runs SB clock-pattern exchange, OOR and DONE req/resp handshakes.
module ltsm_sbinit_ctrl #(
  parameter int TIMEOUT_CYCLES = 800000,
  parameter int DETECT_ITER = 2,
  parameter int POST_ITER = 4,
  parameter int MSG_W = 8,
  parameter logic [MSG_W-1:0] SBINIT_OOR = MSG_W'(8'h91),
  parameter logic [MSG_W-1:0] SBINIT_DONE_REQ = MSG_W'(8'h95),
  parameter logic [MSG_W-1:0] SBINIT_DONE_RESP = MSG_W'(8'h9A)
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             enable_i,
  output logic             pat_tx_en_o,
  input  logic             pat_iter_done_i,
  input  logic             pat_detect_i,
  input  logic             pat_miss_i,
  output logic             tx_msg_valid_o,
  output logic [MSG_W-1:0] tx_msg_code_o,
  input  logic             tx_msg_ready_i,
  input  logic             rx_msg_valid_i,
  input  logic [MSG_W-1:0] rx_msg_code_i,
  output logic             sbinit_done_o,
  output logic             sbinit_error_o,
  output logic [2:0]       state_o
);

  localparam int DW = $clog2(DETECT_ITER + 1);
  localparam int PW = $clog2(POST_ITER + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [DW-1:0] DET_MAX = DW'(DETECT_ITER);
  localparam logic [PW-1:0] POST_MAX = PW'(POST_ITER);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PAT   = 3'd1,
    S_POST  = 3'd2,
    S_OOR   = 3'd3,
    S_DREQ  = 3'd4,
    S_DWAIT = 3'd5,
    S_DONE  = 3'd6,
    S_ERR   = 3'd7
  } state_t;

  state_t state, nst;
  logic [DW-1:0] det_cnt, det_n;
  logic [PW-1:0] post_cnt, post_n;
  logic [TW-1:0] tmo_cnt, tmo_n;
  logic oor_sent, oor_sent_n;
  logic req_sent, req_sent_n;
  logic oor_rx, oor_rx_n;
  logic resp_pend, resp_pend_n;
  logic resp_rx, resp_rx_n;
  logic tx_v_n;
  logic [MSG_W-1:0] tx_c_n;
  logic acc, active, hs;
  logic rx_oor, rx_req, rx_resp;

  assign state_o = state;

  // Next-state, flag and tx-request decode
  always_comb begin
    nst = state;
    det_n = det_cnt;
    post_n = post_cnt;
    tmo_n = tmo_cnt;
    oor_sent_n = oor_sent;
    req_sent_n = req_sent;
    oor_rx_n = oor_rx;
    resp_pend_n = resp_pend;
    resp_rx_n = resp_rx;
    tx_v_n = 1'b0;
    tx_c_n = '0;
    acc = tx_msg_valid_o && tx_msg_ready_i;
    active = state inside {S_PAT, S_POST, S_OOR, S_DREQ, S_DWAIT};
    hs = state inside {S_OOR, S_DREQ, S_DWAIT, S_DONE};
    rx_oor = rx_msg_valid_i && (rx_msg_code_i == SBINIT_OOR);
    rx_req = rx_msg_valid_i && (rx_msg_code_i == SBINIT_DONE_REQ);
    rx_resp = rx_msg_valid_i && (rx_msg_code_i == SBINIT_DONE_RESP);

    if (acc) begin
      if (tx_msg_code_o == SBINIT_OOR) oor_sent_n = 1'b1;
      if (tx_msg_code_o == SBINIT_DONE_REQ) req_sent_n = 1'b1;
      if (tx_msg_code_o == SBINIT_DONE_RESP) resp_pend_n = 1'b0;
    end
    if (rx_oor && state != S_IDLE && state != S_ERR) oor_rx_n = 1'b1;
    if (rx_req && hs) resp_pend_n = 1'b1;
    if (rx_resp && (state == S_DREQ || state == S_DWAIT)) resp_rx_n = 1'b1;
    if (active && tmo_cnt != TMO_MAX) tmo_n = tmo_cnt + TW'(1);

    case (state)
      S_IDLE: nst = S_PAT;
      S_PAT: begin
        if (pat_miss_i) det_n = '0;
        else if (pat_detect_i) det_n = det_cnt + DW'(1);
        if (det_n == DET_MAX) begin
          nst = S_POST;
          post_n = '0;
        end
      end
      S_POST: begin
        if (pat_iter_done_i) post_n = post_cnt + PW'(1);
        if (post_n == POST_MAX) nst = S_OOR;
      end
      S_OOR: if (oor_sent_n && oor_rx_n) nst = S_DREQ;
      S_DREQ: if (req_sent_n) nst = S_DWAIT;
      S_DWAIT: if (resp_rx_n && !resp_pend_n) nst = S_DONE;
      default: ;
    endcase

    if (active && tmo_cnt == TMO_LAST) nst = S_ERR;
    if (!enable_i) nst = S_IDLE;

    // An offered message stays frozen until taken; RESP beats own REQ.
    if (tx_msg_valid_o && !tx_msg_ready_i &&
        nst != S_ERR && nst != S_IDLE) begin
      tx_v_n = 1'b1;
      tx_c_n = tx_msg_code_o;
    end else if (resp_pend_n &&
                 nst inside {S_DREQ, S_DWAIT, S_DONE}) begin
      tx_v_n = 1'b1;
      tx_c_n = SBINIT_DONE_RESP;
    end else if (nst == S_OOR && !oor_sent_n) begin
      tx_v_n = 1'b1;
      tx_c_n = SBINIT_OOR;
    end else if (nst == S_DREQ && !req_sent_n) begin
      tx_v_n = 1'b1;
      tx_c_n = SBINIT_DONE_REQ;
    end
  end

  // State, counters, flags and registered outputs
  always_ff @(posedge clk_100MHz) begin
    if (!reset || nst == S_IDLE) begin
      state <= S_IDLE;
      det_cnt <= '0;
      post_cnt <= '0;
      tmo_cnt <= '0;
      oor_sent <= 1'b0;
      req_sent <= 1'b0;
      oor_rx <= 1'b0;
      resp_pend <= 1'b0;
      resp_rx <= 1'b0;
      pat_tx_en_o <= 1'b0;
      tx_msg_valid_o <= 1'b0;
      tx_msg_code_o <= '0;
      sbinit_done_o <= 1'b0;
      sbinit_error_o <= 1'b0;
    end else begin
      state <= nst;
      det_cnt <= det_n;
      post_cnt <= post_n;
      tmo_cnt <= tmo_n;
      oor_sent <= oor_sent_n;
      req_sent <= req_sent_n;
      oor_rx <= oor_rx_n;
      resp_pend <= resp_pend_n;
      resp_rx <= resp_rx_n;
      pat_tx_en_o <= (nst == S_PAT) || (nst == S_POST);
      tx_msg_valid_o <= tx_v_n;
      tx_msg_code_o <= tx_c_n;
      sbinit_done_o <= (nst == S_DONE);
      sbinit_error_o <= (nst == S_ERR);
    end
  end

endmodule
